instr_packer: RTL

//  Streaming RISC-V instruction encoder/loader; the inverse of the immediate generator.
//  - Accepts decoded instruction fields plus a 32-bit signed immediate.
//  - Packs them into RV32I words in R/I/S/B/U/J format and range-checks the immediate.
//  - Writes words to instruction memory at consecutive word addresses.
//  - Used by the boot/self-test loader to fill IMEM before the core is released from reset.

---
 rtl/instr_packer_pkg.sv | 53 +++++
 rtl/instr_packer_if.sv | 22 ++
 rtl/instr_pack_enc.sv | 51 +++++
 rtl/instr_packer.sv | 113 +++++++++++
 4 files changed

// File: rtl/instr_packer_pkg.sv
// Shared definitions for the instruction packer: format and error encodings,
// FSM states, the pipeline record layout, opcode constants used by loaders
// and benches, and an immediate range helper.
package instr_packer_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_IMM  = 2'b01;
    localparam logic [1:0] ERR_FMT  = 2'b10;
    localparam logic [1:0] ERR_OVF  = 2'b11;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        last;
    } rec_t;

    // True when v[31:msb] are all copies of one bit, i.e. v fits a signed
    // field whose sign bit is at position msb.
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
        logic [31:0] s;
        s = $unsigned($signed(v) >>> msb);
        return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_packer_if.sv
// Record stream into the instruction packer: valid/ready handshake plus the
// decoded instruction fields and a last-record marker.
//   master: record producer (loader / bench)
//   slave : instr_packer
interface instr_packer_if;
    logic        valid;
    logic        ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;

    modport master (output valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, last,
                    input  ready);
    modport slave  (input  valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, last,
                    output ready);
endinterface

// File: rtl/instr_pack_enc.sv
// Combinational RV32I encoder: packs fields + immediate into one word and
// flags an out-of-range immediate or an unknown format.
//   fmt/opcode/funct3/funct7/rd/rs1/rs2/imm : decoded record
//   word      : encoded instruction
//   range_err : immediate does not fit the format
//   fmt_err   : fmt is not one of R/I/S/B/U/J
module instr_pack_enc
    import instr_packer_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_err,
    output logic        fmt_err
);
    always_comb begin
        word      = 32'd0;
        range_err = 1'b0;
        fmt_err   = 1'b0;
        case (fmt_e'(fmt))
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                word      = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !sext_fits(imm, 11);
            end
            FMT_S: begin
                word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !sext_fits(imm, 11);
            end
            FMT_B: begin
                word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = !sext_fits(imm, 12) || imm[0];
            end
            FMT_U: begin
                word      = {imm[31:12], rd, opcode};
                range_err = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_err = !sext_fits(imm, 20) || imm[0];
            end
            default: fmt_err = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_packer.sv
// Streaming instruction packer/loader. Accepts decoded records, encodes them
// two stages later and writes them to IMEM at consecutive word addresses.
//   clk, reset : clock, async active-high reset
//   start      : begin a session (ignored while running)
//   rec        : record stream (slave side)
//   we/waddr/wdata : IMEM write port
//   busy, done : session status; done holds until next start
//   err, err_code, err_addr : sticky first-error report
module instr_packer
    import instr_packer_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_packer_if.slave     rec,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr
);
    state_e            state, state_nxt;
    rec_t              in_rec, s1, s2;
    logic              s1_vld, s2_vld;
    logic              accept, stop, s2_err, restart, full;
    logic [1:0]        s2_code;
    logic [ADDR_W:0]   wr_cnt;   // extra MSB marks "capacity used up"
    logic [31:0]       word;
    logic              range_err, fmt_err;

    assign in_rec = {rec.fmt, rec.opcode, rec.funct3, rec.funct7,
                     rec.rd, rec.rs1, rec.rs2, rec.imm, rec.last};

    instr_pack_enc u_enc (
        .fmt(s2.fmt), .opcode(s2.opcode), .funct3(s2.funct3), .funct7(s2.funct7),
        .rd(s2.rd), .rs1(s2.rs1), .rs2(s2.rs2), .imm(s2.imm),
        .word(word), .range_err(range_err), .fmt_err(fmt_err)
    );

    always_comb begin
        s2_code = ERR_NONE;
        if (fmt_err)        s2_code = ERR_FMT;
        else if (range_err) s2_code = ERR_IMM;
        else if (full)      s2_code = ERR_OVF;
    end

    // Once the counter's top bit is set the low bits read back as BASE again,
    // but nothing is ever written there: any further record is an overflow.
    assign full    = wr_cnt[ADDR_W];
    assign waddr   = ADDR_W'(BASE_ADDR) + wr_cnt[ADDR_W-1:0];
    assign s2_err  = s2_vld && (s2_code != ERR_NONE);
    assign we      = s2_vld && !s2_err;
    assign wdata   = we ? word : 32'd0;

    // Close the input as soon as a last record is in flight or stage 2 faults,
    // so nothing trails a terminating record into the pipe.
    assign stop      = (s1_vld && s1.last) || (s2_vld && (s2.last || s2_err));
    assign rec.ready = (state == ST_RUN) && !stop;
    assign accept    = rec.valid && rec.ready;
    assign restart   = start && (state != ST_RUN);
    assign busy      = (state == ST_RUN) || s1_vld || s2_vld;
    assign done      = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (s2_vld && (s2.last || s2_err)) state_nxt = ST_DONE;
            ST_DONE: if (start) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            s1       <= '0;
            s2       <= '0;
            wr_cnt   <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            err_addr <= '0;
        end else begin
            state  <= state_nxt;
            s1_vld <= accept;
            // a faulting record squashes whatever was accepted behind it
            s2_vld <= s1_vld && !s2_err;
            if (accept) s1 <= in_rec;
            if (s1_vld) s2 <= s1;
            if (restart) begin
                wr_cnt   <= '0;
                err      <= 1'b0;
                err_code <= ERR_NONE;
                err_addr <= '0;
            end else begin
                if (we) wr_cnt <= wr_cnt + 1'b1;
                if (s2_err && !err) begin
                    err      <= 1'b1;
                    err_code <= s2_code;
                    err_addr <= waddr;
                end
            end
        end
    end
endmodule
